// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between core control and muldiv_unit.
// master drives start/funct3/a/b; slave returns busy/done/result.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, fixed 33-cycle latency.
// Ports: clk, rst_n (async, active-low), bus (muldiv_if.slave).
// Macro MULDIV_DIV_EN enables the divider; without it div/rem ops yield 0.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        w_load;
  logic        w_step;
  logic        w_fin;
  logic        w_busy;

  logic [4:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [31:0] r_mc;
  logic [63:0] r_acc;
  logic        r_neg_q;
  logic        r_done;
  logic [31:0] r_result;

  // operand signedness decode
  logic        w_a_signed;
  logic        w_b_signed;
  logic        w_sa;
  logic        w_sb;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  always_comb begin
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    unique case (bus.funct3)
      3'b001: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'b010: w_a_signed = 1'b1;
      3'b100: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
      default: ;
    endcase
  end

  assign w_sa    = w_a_signed & bus.a[31];
  assign w_sb    = w_b_signed & bus.b[31];
  assign w_a_mag = w_sa ? (32'd0 - bus.a) : bus.a;
  assign w_b_mag = w_sb ? (32'd0 - bus.b) : bus.b;

  // shift-add: upper half accumulates, lower half shifts out multiplier
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_prod;

  assign w_mul_sum  = {1'b0, r_acc[63:32]}
                    + (r_acc[0] ? {1'b0, r_mc} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};
  assign w_prod     = r_neg_q ? (64'd0 - r_acc) : r_acc;

`ifdef MULDIV_DIV_EN
  // restoring divide: r_acc[31:0] shifts dividend out, quotient in
  logic [32:0] r_rem;
  logic        r_neg_r;
  logic        r_div0;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_quo;
  logic [31:0] w_rem;

  assign w_shift = {r_rem[31:0], r_acc[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b0, r_mc};
  assign w_qbit  = ~w_diff[33];
  // b==0 already yields rem=|a|; only the quotient needs forcing
  assign w_quo   = r_div0  ? 32'hFFFF_FFFF
                 : r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem   = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
`endif

  logic [31:0] w_res;

  always_comb begin
    w_res = '0;
    unique case (r_f3)
      3'b000:                 w_res = w_prod[31:0];
      3'b001, 3'b010, 3'b011: w_res = w_prod[63:32];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         w_res = w_quo;
      3'b110, 3'b111:         w_res = w_rem;
`else
      3'b100, 3'b101,
      3'b110, 3'b111:         w_res = '0;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    w_busy = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_CALC;
        end
      end
      S_CALC: begin
        w_step = 1'b1;
        if (r_cnt == 5'd0) w_next = S_FIN;
      end
      S_FIN: begin
        w_fin  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_mc     <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
`ifdef MULDIV_DIV_EN
      r_rem    <= '0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`endif
    end else begin
      r_done <= w_fin;
      if (w_fin) r_result <= w_res;
      if (w_load) begin
        r_cnt   <= 5'd31;
        r_f3    <= bus.funct3;
        r_neg_q <= w_sa ^ w_sb;
        if (bus.funct3[2]) begin
          r_mc  <= w_b_mag;
          r_acc <= {32'd0, w_a_mag};
        end else begin
          r_mc  <= w_a_mag;
          r_acc <= {32'd0, w_b_mag};
        end
`ifdef MULDIV_DIV_EN
        r_rem   <= '0;
        r_neg_r <= w_sa;
        r_div0  <= (bus.b == 32'd0);
`endif
      end else if (w_step) begin
        r_cnt <= r_cnt - 5'd1;
`ifdef MULDIV_DIV_EN
        if (r_f3[2]) begin
          r_acc <= {32'd0, r_acc[30:0], w_qbit};
          r_rem <= w_qbit ? w_diff[32:0] : w_shift;
        end else begin
          r_acc <= w_mul_next;
        end
`else
        r_acc <= w_mul_next;
`endif
      end
    end
  end

  assign bus.busy   = w_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random checks of muldiv_unit against
// an arithmetic reference model; latency, busy and reset abort checked.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint    sa;
    longint    sb;
    longint    ua;
    longint    ub;
    logic [63:0] p;
    int        ia;
    int        ib;
    bit        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    model = '0;
    case (f3)
      3'd0: begin p = 64'(ua * ub); model = p[31:0];  end
      3'd1: begin p = 64'(sa * sb); model = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); model = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); model = p[63:32]; end
`ifdef MULDIV_DIV_EN
      3'd4: model = (b == 0) ? 32'hFFFF_FFFF
                  : ovf ? 32'h8000_0000 : 32'(ia / ib);
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: model = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      3'd7: model = (b == 0) ? a : a % b;
`endif
      default: model = '0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'd0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = $urandom_range(0, 15);
      default: pick = $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
  endtask

  task automatic wait_done(input bit mid, output logic [31:0] res);
    int k;
    int nb;
    k  = 0;
    nb = 0;
    while (k < 60) begin
      @(negedge clk);
      k++;
      if (k == 1) bus.start = 1'b0;
      if (mid && k == 10) begin
        bus.start  = 1'b1;
        bus.funct3 = ~bus.funct3;
        bus.a      = bus.a + 32'd1234;
        bus.b      = bus.b ^ 32'h5A5A_5A5A;
      end
      if (mid && k == 11) bus.start = 1'b0;
      if (bus.done) break;
      if (bus.busy) nb++;
    end
    chk("latency", k, 34);
    chk("busy_cycles", nb, 33);
    res = bus.result;
  endtask

  task automatic run(input string tag, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input bit mid);
    logic [31:0] r;
    issue(f3, a, b);
    wait_done(mid, r);
    chk(tag, r, exp);
    @(negedge clk);
    chk("done_pulse", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    bit          seen;

    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.a      = '0;
    bus.b      = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    run("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
`ifdef MULDIV_DIV_EN
    run("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    run("divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run("remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    run("divu0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1'b0);
    run("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1'b0);
    run("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
`else
    run("div_off", 3'd4, 32'd9, 32'd3, 32'd0, 1'b0);
    run("remu_off", 3'd7, 32'd100, 32'd7, 32'd0, 1'b0);
`endif

    // start during CALC must be ignored
    run("mul_mid", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);

    // back-to-back: second start in the done cycle
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, r);
    chk("b2b_first", r, 32'hFFFF_FFFE);
    issue(3'd0, 32'd12345, 32'd678);
    wait_done(1'b0, r);
    chk("b2b_second", r, 32'd8369910);
    @(negedge clk);

    // reset abort in the middle of CALC
    issue(3'd0, 32'd3, 32'd5);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_result", bus.result, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    run("post_abort", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      run($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, model(f3, a, b),
          1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
